program_sequencer: RTL and testbench

Program buffer and step-clock generator directly upstream of the processor. A host writes 16-bit instruction and data words into a small buffer through a valid/ready port. On `start`, the block replays the words on the processor's 16-bit data input (`switchIn`). It decodes each opcode to find how many processor steps the instruction needs and issues one `stepPulse` per step, in place of the manual push-button clock. It also drives the processor run enable `w`.

---
 rtl/proc_pkg.sv | 33 +++
 rtl/step_timer.sv | 33 +++
 rtl/program_sequencer.sv | 150 +++++++++++++++
 tb/tb_program_sequencer.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for the processor front end: opcodes, sequencer states
// and the per-opcode step count used by the program sequencer.
package proc_pkg;

  localparam int OP_W = 7;
  typedef logic [OP_W-1:0] opcode_t;

  localparam opcode_t OP_LOAD = 7'b0000000;
  localparam opcode_t OP_MOVE = 7'b0000001;
  localparam opcode_t OP_ADD  = 7'b1000010;
  localparam opcode_t OP_SUB  = 7'b1000011;
  localparam opcode_t OP_OR   = 7'b1000100;
  localparam opcode_t OP_AND  = 7'b1000101;
  localparam opcode_t OP_NOT  = 7'b1000110;
  localparam opcode_t OP_NEG  = 7'b1000111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  // Processor steps needed by an opcode; 0 marks an illegal opcode.
  function automatic logic [2:0] steps_for(input opcode_t op);
    case (op)
      OP_LOAD, OP_MOVE:               steps_for = 3'd2;
      OP_ADD, OP_SUB, OP_OR, OP_AND:  steps_for = 3'd4;
      OP_NOT, OP_NEG:                 steps_for = 3'd3;
      default:                        steps_for = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/step_timer.sv
// Free-running step timer: counts 0..STEP_CYCLES-1 while enabled and is held
// at 0 otherwise, so every run starts with a full step.
module step_timer #(
  parameter int STEP_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic pulse,
  output logic first
);

  localparam int TW = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [TW-1:0] LAST = TW'(STEP_CYCLES - 1);

  logic [TW-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (!enable || cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + TW'(1);
    end
  end

  assign pulse = enable && (cnt_q == LAST);
  assign first = enable && (cnt_q == '0);

endmodule

// File: rtl/program_sequencer.sv
// Program buffer and step-clock generator: stores host words, then replays them
// on switchIn with one stepPulse per processor step of each decoded opcode.
module program_sequencer
  import proc_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int AW          = $clog2(DEPTH),
  parameter int STEP_CYCLES = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [15:0]   wr_data,
  input  logic          start,
  input  logic          clear,
  output logic [15:0]   switchIn,
  output logic          stepPulse,
  output logic          w,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] pc
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [15:0]   mem [DEPTH];
  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW:0]   count_q, count_d;
  logic [1:0]    step_q, step_d;
  logic          done_q, done_d, err_q, err_d;

  logic          running, tick, first, wr_fire, wr_en;
  opcode_t       op;
  logic          is_load, truncated, last_step;
  logic [2:0]    n_steps;
  logic [AW:0]   pc_next;
  logic [AW-1:0] rd_idx;

  assign running = (state_q == RUN);

  step_timer #(.STEP_CYCLES(STEP_CYCLES)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .enable (running),
    .pulse  (tick),
    .first  (first)
  );

  // The opcode word stays at mem[pc] for the whole instruction; writes are
  // blocked in RUN, so decoding it combinationally is stable.
  assign op        = mem[pc_q][15:9];
  assign is_load   = (op == OP_LOAD);
  assign n_steps   = steps_for(op);
  assign truncated = is_load && ({1'b0, pc_q} == count_q - (AW+1)'(1));
  assign last_step = (step_q == 2'(n_steps - 3'd1));
  assign pc_next   = {1'b0, pc_q} + (is_load ? (AW+1)'(2) : (AW+1)'(1));
  assign rd_idx    = pc_q + AW'(is_load && (step_q != 2'd0));

  assign wr_ready = !running && (count_q < FULL);
  assign wr_fire  = wr_valid && wr_ready;
  assign wr_en    = wr_fire && !clear;

  always_comb begin
    // NOTE: every target gets a default first so no path can infer a latch.
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    step_d  = step_q;
    done_d  = done_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE, HALT: begin
        if (clear) begin
          count_d = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
          state_d = IDLE;
        end else begin
          if (wr_fire) count_d = count_q + (AW+1)'(1);
          if (start) begin
            if (count_q == '0) begin
              done_d = 1'b1;
            end else begin
              state_d = RUN;
              pc_d    = '0;
              step_d  = '0;
              done_d  = 1'b0;
              err_d   = 1'b0;
            end
          end
        end
      end
      RUN: begin
        // Bad words are caught on their first presented cycle, before any pulse.
        if (first && step_q == 2'd0 && (n_steps == 3'd0 || truncated)) begin
          state_d = HALT;
          err_d   = 1'b1;
          done_d  = 1'b1;
        end else if (tick) begin
          if (last_step) begin
            step_d = '0;
            pc_d   = pc_next[AW-1:0];
            if (pc_next >= count_q) begin
              state_d = HALT;
              done_d  = 1'b1;
            end
          end else begin
            step_d = step_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      count_q <= '0;
      step_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      step_q  <= step_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // NOTE: the buffer has no reset; count alone decides which words are valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[count_q[AW-1:0]] <= wr_data;
  end

  assign switchIn  = running ? mem[rd_idx] : 16'h0000;
  assign stepPulse = tick;
  assign w         = running;
  assign busy      = running;
  assign done      = done_q;
  assign err       = err_q;
  assign pc        = pc_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Self-checking bench for program_sequencer: a timeline model built from the
// program contents is compared against the DUT every cycle.
module tb_program_sequencer;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int S     = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_valid = 1'b0;
  logic [15:0]   wr_data = 16'h0;
  logic          start = 1'b0;
  logic          clear = 1'b0;
  logic          wr_ready, stepPulse, w, busy, done, err;
  logic [15:0]   switchIn;
  logic [AW-1:0] pc;

  always #5 clk = ~clk;

  program_sequencer #(.DEPTH(DEPTH), .AW(AW), .STEP_CYCLES(S)) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .start     (start),
    .clear     (clear),
    .switchIn  (switchIn),
    .stepPulse (stepPulse),
    .w         (w),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .pc        (pc)
  );

  typedef struct packed {
    logic          pulse;
    logic [15:0]   sw;
    logic [AW-1:0] pc;
  } exp_t;

  exp_t          exp_q[$];     // one entry per expected RUN cycle
  logic [15:0]   m_mem[$];     // stored program; size() is the word count
  logic          m_done = 1'b0, m_err = 1'b0;
  logic [AW-1:0] m_pc = '0;
  logic          checking = 1'b0;

  int total = 0, bad = 0;
  int cyc = 0, start_cyc = 0, pulse_cnt = 0;
  int pulse_cyc[$];
  logic [15:0] pulse_sw[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int n_steps(input logic [6:0] op);
    if (op == 7'h00 || op == 7'h01) return 2;
    if (op >= 7'h42 && op <= 7'h45) return 4;
    if (op == 7'h46 || op == 7'h47) return 3;
    return 0;
  endfunction

  // Expand the stored program into the cycle-by-cycle RUN timeline.
  task automatic model_start();
    int p, n;
    logic [6:0] op;
    exp_t e;
    if (m_mem.size() == 0) begin
      m_done = 1'b1;
      return;
    end
    m_done = 1'b0;
    m_err  = 1'b0;
    p = 0;
    while (p < m_mem.size()) begin
      op = m_mem[p][15:9];
      n  = n_steps(op);
      if (n == 0 || (op == 7'h00 && p == m_mem.size() - 1)) begin
        e.pulse = 1'b0;
        e.sw    = m_mem[p];
        e.pc    = AW'(p);
        exp_q.push_back(e);
        m_err = 1'b1;
        m_pc  = AW'(p);
        break;
      end
      for (int s = 0; s < n; s++) begin
        for (int c = 0; c < S; c++) begin
          e.pulse = (c == S - 1);
          e.sw    = (op == 7'h00 && s == 1) ? m_mem[p+1] : m_mem[p];
          e.pc    = AW'(p);
          exp_q.push_back(e);
        end
      end
      p += (op == 7'h00) ? 2 : 1;
      m_pc = AW'(p);
    end
    m_done = 1'b1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset && stepPulse) begin
      pulse_cnt++;
      pulse_cyc.push_back(cyc);
      pulse_sw.push_back(switchIn);
    end
  end

  always @(negedge clk) begin : compare
    exp_t e;
    if (!reset && checking) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("run_w", w, 1);
        check("run_busy", busy, 1);
        check("run_pulse", stepPulse, e.pulse);
        check("run_switchIn", switchIn, e.sw);
        check("run_pc", pc, e.pc);
        check("run_done", done, 0);
        check("run_err", err, 0);
        check("run_wr_ready", wr_ready, 0);
      end else begin
        check("idle_w", w, 0);
        check("idle_busy", busy, 0);
        check("idle_pulse", stepPulse, 0);
        check("idle_done", done, m_done);
        check("idle_err", err, m_err);
        check("idle_wr_ready", wr_ready, m_mem.size() < DEPTH);
        check("idle_pc", pc, m_pc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [15:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    @(posedge clk);
    if (m_mem.size() < DEPTH) m_mem.push_back(d);
    #1 wr_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    model_start();
    #1 start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic do_clear(input logic with_start);
    clear = 1'b1;
    start = with_start;
    @(posedge clk);
    m_mem.delete();
    m_done = 1'b0;
    m_err  = 1'b0;
    #1;
    clear = 1'b0;
    start = 1'b0;
  endtask

  // Wait out the expected run; optional host writes that must all be dropped.
  task automatic wait_idle(input logic noisy);
    int budget = 3000;
    while (exp_q.size() > 0 && budget > 0) begin
      wr_valid = noisy && ($urandom_range(0, 2) == 0);
      wr_data  = 16'($urandom);
      tick();
      budget--;
    end
    wr_valid = 1'b0;
    check("run_finished_in_budget", exp_q.size(), 0);
    exp_q.delete();
    tick();
  endtask

  function automatic logic [15:0] rand_legal_alu();
    logic [6:0] op;
    op = 7'h42 + 7'($urandom_range(0, 5));
    return {op, 9'($urandom)};
  endfunction

  task automatic rand_prog(input int n);
    logic [6:0] op;
    int k;
    for (int i = 0; i < n; i++) begin
      k = $urandom_range(0, 9);
      if (k <= 1) begin
        write_word({7'h00, 9'($urandom)});
        if ($urandom_range(0, 3) != 0 || i != n - 1) write_word(16'($urandom));
      end else if (k <= 3) begin
        write_word({7'h01, 9'($urandom)});
      end else if (k <= 8) begin
        write_word(rand_legal_alu());
      end else begin
        do op = 7'($urandom); while (n_steps(op) != 0);
        write_word({op, 9'($urandom)});
      end
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("reset_wr_ready", wr_ready, 1);
    check("reset_w", w, 0);
    check("reset_busy", busy, 0);
    check("reset_pulse", stepPulse, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    check("reset_pc", pc, 0);
    check("reset_switchIn", switchIn, 16'h0000);
    checking = 1'b1;

    // Load with data word.
    base = pulse_cnt;
    write_word(16'h0040);
    write_word(16'h0005);
    do_start();
    wait_idle(1'b0);
    check("load_pulses", pulse_cnt - base, 2);
    check("load_first_pulse_latency", pulse_cyc[base] - start_cyc, 3);
    check("load_pulse_gap", pulse_cyc[base+1] - pulse_cyc[base], 4);
    check("load_sw0", pulse_sw[base], 16'h0040);
    check("load_sw1", pulse_sw[base+1], 16'h0005);
    check("load_done", done, 1);
    check("load_err", err, 0);
    check("load_w", w, 0);

    // add then not: 4 + 3 steps back to back.
    do_clear(1'b0);
    base = pulse_cnt;
    write_word(16'h8450);
    write_word(16'h8C50);
    do_start();
    wait_idle(1'b1);
    check("mixed_pulses", pulse_cnt - base, 7);
    check("mixed_last_pulse", pulse_cyc[base+6] - start_cyc, 27);
    check("mixed_sw_not", pulse_sw[base+4], 16'h8C50);
    check("mixed_pc", pc, 2);

    // Move followed by an illegal opcode.
    do_clear(1'b0);
    base = pulse_cnt;
    write_word(16'h0200);
    write_word(16'h2000);
    do_start();
    wait_idle(1'b0);
    check("illegal_pulses", pulse_cnt - base, 2);
    check("illegal_err", err, 1);
    check("illegal_done", done, 1);
    check("illegal_pc", pc, 1);

    // Load with no data word.
    do_clear(1'b0);
    base = pulse_cnt;
    write_word(16'h0040);
    do_start();
    wait_idle(1'b0);
    check("trunc_pulses", pulse_cnt - base, 0);
    check("trunc_err", err, 1);
    check("trunc_done", done, 1);

    // Full buffer: 17th write dropped, whole 16-word program replayed.
    do_clear(1'b0);
    for (int i = 0; i < DEPTH; i++) write_word(rand_legal_alu());
    check("full_wr_ready", wr_ready, 0);
    write_word(16'hFFFF);
    check("full_wr_ready_after_drop", wr_ready, 0);
    do_start();
    wait_idle(1'b1);
    check("full_pc_wrap", pc, 0);
    do_clear(1'b0);
    check("clear_wr_ready", wr_ready, 1);

    // start during RUN is ignored.
    base = pulse_cnt;
    write_word(16'h8450);
    do_start();
    repeat (5) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle(1'b0);
    check("start_in_run_pulses", pulse_cnt - base, 4);

    // clear and start together in HALT: clear wins.
    base = pulse_cnt;
    do_clear(1'b1);
    repeat (5) tick();
    check("collide_w", w, 0);
    check("collide_done", done, 0);
    check("collide_wr_ready", wr_ready, 1);
    check("collide_pulses", pulse_cnt - base, 0);

    // Reset during the second step of an add.
    write_word(16'h8450);
    base = pulse_cnt;
    do_start();
    repeat (5) tick();
    reset = 1'b1;
    exp_q.delete();
    m_mem.delete();
    m_done = 1'b0;
    m_err  = 1'b0;
    m_pc   = '0;
    #1;
    check("midrst_w", w, 0);
    check("midrst_pulse", stepPulse, 0);
    check("midrst_switchIn", switchIn, 16'h0000);
    check("midrst_busy", busy, 0);
    check("midrst_pulses_before", pulse_cnt - base, 1);
    repeat (3) tick();
    reset = 1'b0;
    repeat (10) tick();
    check("midrst_no_more_pulses", pulse_cnt - base, 1);
    check("midrst_wr_ready", wr_ready, 1);
    do_start();
    tick();
    check("midrst_empty_start_done", done, 1);
    check("midrst_empty_start_w", w, 0);

    // Randomized programs against the timeline model.
    for (int it = 0; it < 14; it++) begin
      do_clear(1'b0);
      rand_prog($urandom_range(1, 7));
      repeat ($urandom_range(0, 3)) tick();
      do_start();
      wait_idle(1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
